// File: rtl/bus_rr.sv
// bus_rr: N-host x M-device interconnect, round-robin arbitration,
// one transaction in flight, wait states, timeout and decode-miss errors.
module bus_rr #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int RespTimeout  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],
    output logic                      device_req_o         [NrDevices],
    input  logic                      device_gnt_i         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int CntW  = $clog2(RespTimeout);
    localparam logic [CntW-1:0] CntMax = CntW'(RespTimeout - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [HostW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [HostW-1:0]       host_q, host_d;
    logic [DevW-1:0]        dev_q, dev_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   win_valid;
    logic [HostW-1:0]       win_idx;
    logic                   win_hit;
    logic [DevW-1:0]        win_dev;

    logic                   fwd_en;
    logic [HostW-1:0]       fwd_host;
    logic [DevW-1:0]        fwd_dev;
    logic                   gnt_en;
    logic [HostW-1:0]       gnt_host;
    logic                   rsp_en;
    logic [DataWidth-1:0]   rsp_rdata;
    logic                   rsp_err;
    logic [NrDevices-1:0]   dev_sel;

    function automatic logic [HostW-1:0] ptr_next(logic [HostW-1:0] h);
        if (h == HostW'(NrHosts - 1)) begin
            return '0;
        end
        return h + HostW'(1);
    endfunction

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) begin
                win_valid = 1'b1;
                win_idx   = HostW'(i);
            end
        end
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i] && (HostW'(i) >= rr_ptr_q)) begin
                win_valid = 1'b1;
                win_idx   = HostW'(i);
            end
        end
    end

    // Address decode of the winner; lowest matching device index wins
    always_comb begin
        win_hit = 1'b0;
        win_dev = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((host_addr_i[win_idx] & cfg_device_addr_mask[d])
                == cfg_device_addr_base[d]) begin
                win_hit = 1'b1;
                win_dev = DevW'(d);
            end
        end
    end

    // Transaction FSM next-state and control; reset silences everything
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        host_d    = host_q;
        dev_d     = dev_q;
        cnt_d     = cnt_q;
        fwd_en    = 1'b0;
        fwd_host  = host_q;
        fwd_dev   = dev_q;
        gnt_en    = 1'b0;
        gnt_host  = host_q;
        rsp_en    = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (win_valid && win_hit) begin
                        fwd_en   = 1'b1;
                        fwd_host = win_idx;
                        fwd_dev  = win_dev;
                        host_d   = win_idx;
                        dev_d    = win_dev;
                        if (device_gnt_i[win_dev]) begin
                            gnt_en   = 1'b1;
                            gnt_host = win_idx;
                            rr_ptr_d = ptr_next(win_idx);
                            cnt_d    = '0;
                            state_d  = RESP;
                        end else begin
                            state_d  = ADDR;
                        end
                    end else if (win_valid) begin
                        gnt_en   = 1'b1;
                        gnt_host = win_idx;
                        host_d   = win_idx;
                        rr_ptr_d = ptr_next(win_idx);
                        state_d  = ERR;
                    end
                end
                ADDR: begin
                    fwd_en = 1'b1;
                    if (device_gnt_i[dev_q]) begin
                        gnt_en   = 1'b1;
                        rr_ptr_d = ptr_next(host_q);
                        cnt_d    = '0;
                        state_d  = RESP;
                    end
                end
                RESP: begin
                    if (device_rvalid_i[dev_q]) begin
                        rsp_en    = 1'b1;
                        rsp_rdata = device_rdata_i[dev_q];
                        rsp_err   = device_err_i[dev_q];
                        state_d   = IDLE;
                    end else if (cnt_q == CntMax) begin
                        rsp_en  = 1'b1;
                        rsp_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ERR: begin
                    rsp_en  = 1'b1;
                    rsp_err = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output steering: only the selected device and target host see activity
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = gnt_en && (gnt_host == HostW'(h));
            host_rvalid_o[h] = rsp_en && (host_q == HostW'(h));
            host_rdata_o[h]  = host_rvalid_o[h] ? rsp_rdata : '0;
            host_err_o[h]    = host_rvalid_o[h] && rsp_err;
        end
        for (int d = 0; d < NrDevices; d++) begin
            dev_sel[d]        = fwd_en && (fwd_dev == DevW'(d));
            device_req_o[d]   = dev_sel[d];
            device_addr_o[d]  = dev_sel[d] ? host_addr_i[fwd_host] : '0;
            device_we_o[d]    = dev_sel[d] && host_we_i[fwd_host];
            device_be_o[d]    = dev_sel[d] ? host_be_i[fwd_host] : '0;
            device_wdata_o[d] = dev_sel[d] ? host_wdata_i[fwd_host] : '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            host_q   <= '0;
            dev_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            host_q   <= host_d;
            dev_q    <= dev_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
